// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// default operand width and the bit-index width helper.
package serial_addsub_pkg;

    // Control states: waiting, shifting bits through the adder, result valid
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default operand/result width
    localparam int DEFAULT_WIDTH = 8;

    // Width of the bit index counter: enough to address bits 0..w-1
    function automatic int idx_width(input int w);
        if (w < 2) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder used as the arithmetic core of the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational full-adder equations
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// then shifted LSB first through one full-adder cell, one bit per cycle.
// Subtraction is A + ~B + 1, so cout=1 means "no borrow".
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic             carry_reg, carry_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_shifted;

    // The one arithmetic cell, always fed from the LSBs of the operand shifters
    full_adder_cell u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New result bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB
    assign res_shifted = {fa_sum, res_sh_reg[WIDTH-1:1]};

    // Next-state and datapath decisions; every register holds unless told otherwise
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        carry_next  = carry_reg;
        idx_next    = idx_reg;
        sum_next    = sum_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Capture operands; subtraction is folded into ~B with carry-in 1
                    a_sh_next   = a;
                    b_sh_next   = sub ? ~b : b;
                    carry_next  = sub ? 1'b1 : cin;
                    idx_next    = '0;
                    res_sh_next = '0;
                    state_next  = ST_RUN;
                end else begin
                    // DONE only ever lasts one cycle, which makes it the done pulse
                    state_next = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Drop the operation; published results stay untouched
                    state_next = ST_IDLE;
                end else begin
                    a_sh_next   = a_sh_reg >> 1;
                    b_sh_next   = b_sh_reg >> 1;
                    res_sh_next = res_shifted;
                    carry_next  = fa_cout;
                    idx_next    = idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        // MSB cycle: carry_reg is the carry into the MSB
                        sum_next   = res_shifted;
                        cout_next  = fa_cout;
                        ovf_next   = carry_reg ^ fa_cout;
                        state_next = ST_DONE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            carry_reg  <= carry_next;
            idx_reg    <= idx_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Status flags decode directly from the state register
    always_comb begin
        busy = (state_reg == ST_RUN);
        done = (state_reg == ST_DONE);
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
`timescale 1ns/1ps
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Step to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, scramble inputs, measure latency/busy, check results
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [7:0] esum, input logic ecout, input logic eovf);
        int n;
        int bcnt;
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = ~vcin; sub = ~vsub;
        n = 0;
        bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            step();
            n++;
        end
        check({tag, " latency"}, n, 8);
        check({tag, " busy_cycles"}, bcnt, 8);
        check({tag, " sum"}, sum, esum);
        check({tag, " cout"}, cout, ecout);
        check({tag, " overflow"}, overflow, eovf);
        step();
        check({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sub = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("add_0f_01_cin", 8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_05_07_c1", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_05_07_c0", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Abort: sum must keep 0x7F from the previous operation
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        dcnt = 0;
        repeat (2) begin step(); if (done) dcnt++; end
        a = 8'h33; b = 8'h44; start = 1'b1;
        step();
        if (done) dcnt++;
        start = 1'b0;
        check("abort busy_before", busy, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy_after", busy, 0);
        repeat (12) begin if (done) dcnt++; step(); end
        check("abort done_pulses", dcnt, 0);
        check("abort busy_idle", busy, 0);
        check("abort sum_kept", sum, 8'h7F);
        run_op("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        // Abort ignored outside RUN
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle sum", sum, 8'h30);

        // Back-to-back: start held through DONE
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        a = 8'hEE; b = 8'hEE;
        repeat (7) step();
        check("b2b first_not_done", done, 0);
        step();
        check("b2b first_done", done, 1);
        check("b2b first_sum", sum, 8'h03);
        a = 8'h03; b = 8'h04;
        step();
        start = 1'b0;
        check("b2b accepted_busy", busy, 1);
        check("b2b accepted_no_done", done, 0);
        repeat (7) step();
        check("b2b second_not_done", done, 0);
        step();
        check("b2b second_done", done, 1);
        check("b2b second_sum", sum, 8'h07);
        step();

        // Reset mid-RUN clears everything at once
        a = 8'hFF; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        check("rst_mid sum", sum, 0);
        check("rst_mid cout", cout, 0);
        check("rst_mid overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin step(); if (done || busy) dcnt++; end
        check("rst_mid stays_idle", dcnt, 0);
        run_op("after_reset", 8'h22, 8'h11, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
